// File: rtl/text_memory_port.sv
`default_nettype none
// ============================================================================
//  Module   : text_memory_port
//  Purpose  : Single-port word memory behind a valid/ready request channel
//             and a valid/ready response channel. One request may be
//             accepted per cycle. Its response appears on the following
//             cycle and is held until the consumer takes it.
//  Ports    : clk, reset (asynchronous, active-high)
//             req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb
//             resp_valid/resp_ready/resp_rdata/resp_fault
//  Config   : TEXT_MEM_FAULT_EN. When defined, requests that are out of
//             range or misaligned respond with resp_fault=1 and have no
//             other effect. When undefined, resp_fault is tied to 0, the
//             low address bits are ignored, out-of-range reads return 0
//             and out-of-range writes are dropped.
//  Revision : 1.0  initial release
// ============================================================================
module text_memory_port #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0040_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_fault
);

    localparam int          c_BPW  = DATA_WIDTH / 8;
    localparam int          c_LSB  = $clog2(c_BPW);
    localparam int          c_AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_SPAN = 32'(DEPTH_WORDS * c_BPW);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_rd_sel;   // pending response carries read data
    logic                    r_fault;
    logic [DATA_WIDTH-1:0]   r_mem_q;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];

    logic [31:0]             w_offset;
    logic [c_AW-1:0]         w_index;
    logic                    w_in_range;
    logic                    w_fault;
    logic                    w_accept;
    logic                    w_do_write;
    logic                    w_do_read;

    // The unsigned subtraction wraps addresses below the base to large
    // values, so one compare covers both ends of the window.
    assign w_offset   = req_addr - BASE_ADDR;
    assign w_in_range = (w_offset < c_SPAN);
    assign w_index    = w_offset[c_LSB +: c_AW];

`ifdef TEXT_MEM_FAULT_EN
    localparam logic [31:0] c_ALIGN_MASK = 32'(c_BPW - 1);
    logic w_misaligned;
    assign w_misaligned = ((w_offset & c_ALIGN_MASK) != 32'd0);
    assign w_fault      = !w_in_range || w_misaligned;
`else
    assign w_fault      = 1'b0;
`endif

    assign resp_valid = (r_state == S_RESP);
    // Gating with reset keeps the port closed, and the memory untouched,
    // for as long as reset is held.
    assign req_ready  = !reset && (!resp_valid || resp_ready);
    assign w_accept   = req_valid && req_ready;
    assign w_do_write = w_accept &&  req_write && w_in_range && !w_fault;
    assign w_do_read  = w_accept && !req_write && w_in_range && !w_fault;

    // The storage is not reset. Its read register only loads on a
    // read accept, so it holds steady while a response is stalled.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < c_BPW; b++) begin
                if (req_wstrb[b]) begin
                    r_mem[w_index][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
        if (w_do_read) begin
            r_mem_q <= r_mem[w_index];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rd_sel <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_accept) begin
                        r_state <= S_RESP;
                    end else if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_accept) begin
                r_rd_sel <= w_do_read;
                r_fault  <= w_fault;
            end
        end
    end

    // Write, fault and out-of-range responses read as zero.
    assign resp_rdata = r_rd_sel ? r_mem_q : '0;
    assign resp_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_text_memory_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_text_memory_port
//  Purpose  : Self-checking bench for text_memory_port. It drives directed
//             and random stimulus and compares the DUT against a
//             behavioural model of the port: a word array plus one pending
//             response slot.
//  Revision : 1.0  initial release
// ============================================================================
module tb_text_memory_port;

    localparam logic [31:0] c_BASE = 32'h0040_0000;
    localparam logic [31:0] c_SPAN = 32'd4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    text_memory_port dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [31:0] m_mem [1024];
    logic        m_valid = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic        m_fault = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compute the response to a request from the address rules alone.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] rd, output logic f);
        logic in_r;
        logic aligned;
        int   idx;
        in_r    = (a >= c_BASE) && (a < c_BASE + c_SPAN);
        aligned = (a % 4) == 0;
`ifdef TEXT_MEM_FAULT_EN
        f = !in_r || !aligned;
`else
        f = 1'b0;
`endif
        rd  = 32'd0;
        idx = int'((a - c_BASE) / 4);
        if (in_r && !f) begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
            end else begin
                rd = m_mem[idx];
            end
        end
    endtask

    // One clock cycle. The task is entered at a negedge. It drives the
    // request, checks req_ready before the edge, then checks the response
    // just after the edge.
    task automatic cycle(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic rr);
        logic        exp_ready;
        logic        acc;
        logic [31:0] nrd;
        logic        nf;
        req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        resp_ready = rr;
        #1;
        exp_ready = !m_valid || rr;
        check("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            model_access(w, a, d, s, nrd, nf);
            m_valid = 1'b1;
            m_rdata = nrd;
            m_fault = nf;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        check("resp_valid", {63'd0, resp_valid}, {63'd0, m_valid});
        if (m_valid) begin
            check("resp_rdata", {32'd0, resp_rdata}, {32'd0, m_rdata});
            check("resp_fault", {63'd0, resp_fault}, {63'd0, m_fault});
        end
        @(negedge clk);
    endtask

    task automatic rd_req(input logic [31:0] a, input logic rr);
        cycle(1'b1, 1'b0, a, $urandom, 4'($urandom), rr);
    endtask

    task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cycle(1'b1, 1'b1, a, d, s, 1'b1);
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom), rr);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 8)       return c_BASE + 4 * $urandom_range(0, 31);
        else if (sel == 8) return c_BASE + $urandom_range(0, 127);
        else               return ($urandom_range(0, 1) == 1) ? c_BASE + c_SPAN + 4 * $urandom_range(0, 7)
                                                               : c_BASE - 4;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;

        // Outputs held quiet while reset is asserted.
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
        check("rst_resp_fault", {63'd0, resp_fault}, 64'd0);
        check("rst_req_ready",  {63'd0, req_ready},  64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fill the words used by the random phase, back-to-back.
        for (int i = 0; i < 32; i++) wr_req(c_BASE + 4 * i, $urandom, 4'hF);
        idle(1'b1);

        // Full write, then read back.
        wr_req(32'h0040_0010, 32'hDEAD_BEEF, 4'hF);
        rd_req(32'h0040_0010, 1'b1);
        idle(1'b1);
        check("dir_deadbeef", {32'd0, m_rdata}, 64'hDEAD_BEEF);

        // Single-byte write merges into the existing word.
        wr_req(32'h0040_0010, 32'h0000_5A00, 4'b0010);
        rd_req(32'h0040_0010, 1'b1);
        check("dir_merge", {32'd0, resp_rdata}, 64'hDEAD_5AEF);
        // A zero strobe leaves the word unchanged.
        wr_req(32'h0040_0010, 32'hFFFF_FFFF, 4'b0000);
        rd_req(32'h0040_0010, 1'b1);
        idle(1'b1);

        // Stall: the response holds and no request is accepted.
        rd_req(32'h0040_0000, 1'b0);
        for (int i = 0; i < 3; i++) rd_req(rand_addr(), 1'b0);
        idle(1'b1);

        // Out-of-range and misaligned reads.
        rd_req(32'h0040_1000, 1'b1);
        rd_req(32'h0040_0002, 1'b1);
        idle(1'b1);

        // Four back-to-back reads.
        for (int i = 0; i < 4; i++) rd_req(c_BASE + 4 * (i + 8), 1'b1);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), rand_addr(), $urandom,
                  4'($urandom), 1'($urandom_range(0, 9) < 7));
        end
        idle(1'b1);

        // Reset while a response is pending.
        rd_req(c_BASE + 4 * 5, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("arst_req_ready",  {63'd0, req_ready},  64'd0);
        check("arst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
        m_valid = 1'b0;
        // A write presented during reset must not reach memory.
        req_valid = 1'b1; req_write = 1'b1; req_addr = c_BASE + 4 * 5;
        req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd_req(c_BASE + 4 * 5, 1'b1);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
